// File: rtl/bcd_calc_core.sv
// bcd_calc_core: NDIGITS-wide BCD keypad entry register with a digit-serial
// add/subtract engine. All outputs are registered.
module bcd_calc_core #(
    parameter int NDIGITS = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           digit,
    input  logic                 keystrobe,
    output logic [4*NDIGITS-1:0] bcd_out,
    output logic                 negative,
    output logic                 overflow,
    output logic                 busy
);
    // state   | meaning
    // ENTER_A | keying first operand, display opA
    // ENTER_B | keying second operand, display opB
    // COMPARE | order operands for subtract, set sign
    // COMPUTE | one BCD digit per cycle, LSD first
    // RESULT  | display result and flags

    localparam int W = 4 * NDIGITS;

    typedef enum logic [2:0] {ENTER_A, ENTER_B, COMPARE, COMPUTE, RESULT} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [W-1:0] x_q, x_d, y_q, y_d, res_q, res_d;
    logic [W-1:0] bcd_out_q, bcd_out_d;
    logic         op_sub_q, op_sub_d, carry_q, carry_d;
    logic         neg_q, neg_d, ovf_q, ovf_d;
    logic         negative_q, negative_d, overflow_q, overflow_d, busy_q, busy_d;
    logic [3:0]   cnt_q, cnt_d;

    logic         key, clear, act_wr, flags_clr;
    logic [W-1:0] act, act_new;
    logic [4:0]   dsum;
    logic [3:0]   dres;
    logic         dcarry;

    // Single-digit BCD adder/subtractor on the LSD of the working operands.
    always_comb begin
        dsum   = 5'd0;
        dres   = 4'd0;
        dcarry = 1'b0;
        if (op_sub_q) begin
            dsum   = {1'b0, x_q[3:0]} - {1'b0, y_q[3:0]} - {4'd0, carry_q};
            dcarry = dsum[4];
            dres   = dcarry ? dsum[3:0] + 4'd10 : dsum[3:0];
        end else begin
            dsum   = {1'b0, x_q[3:0]} + {1'b0, y_q[3:0]} + {4'd0, carry_q};
            dcarry = (dsum > 5'd9);
            dres   = dcarry ? dsum[3:0] + 4'd6 : dsum[3:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        x_d        = x_q;
        y_d        = y_q;
        res_d      = res_q;
        op_sub_d   = op_sub_q;
        carry_d    = carry_q;
        neg_d      = neg_q;
        ovf_d      = ovf_q;
        cnt_d      = cnt_q;
        bcd_out_d  = bcd_out_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        key        = keystrobe && !busy_q;
        clear      = 1'b0;
        act        = (state_q == ENTER_B) ? opb_q : opa_q;
        act_new    = act;
        act_wr     = 1'b0;
        flags_clr  = !neg_q && !ovf_q;

        case (state_q)
            ENTER_A, ENTER_B: begin
                if (key) begin
                    if (digit <= 4'd9) begin
                        // A nonzero MSD means the operand is full.
                        if (act[W-1 -: 4] == 4'd0) begin
                            act_new = (act << 4) | W'(digit);
                            act_wr  = 1'b1;
                        end
                    end else begin
                        case (digit)
                            4'hA, 4'hB: begin
                                op_sub_d = digit[0];
                                if (state_q == ENTER_A) opb_d = '0;
                                state_d = ENTER_B;
                            end
                            4'hC: clear = 1'b1;
                            4'hD: if (state_q == ENTER_B) state_d = COMPARE;
                            4'hE: begin
                                act_new = act >> 4;
                                act_wr  = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            COMPARE: begin
                if (op_sub_q && (opa_q < opb_q)) begin
                    x_d   = opb_q;
                    y_d   = opa_q;
                    neg_d = 1'b1;
                end else begin
                    x_d   = opa_q;
                    y_d   = opb_q;
                    neg_d = 1'b0;
                end
                ovf_d   = 1'b0;
                carry_d = 1'b0;
                cnt_d   = 4'(NDIGITS - 1);
                state_d = COMPUTE;
            end
            COMPUTE: begin
                x_d     = x_q >> 4;
                y_d     = y_q >> 4;
                res_d   = (res_q >> 4) | (W'(dres) << (W - 4));
                carry_d = dcarry;
                if (cnt_q == 4'd0) begin
                    state_d = RESULT;
                    ovf_d   = !op_sub_q && dcarry;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESULT: begin
                if (key) begin
                    if (digit <= 4'd9) begin
                        opa_d   = W'(digit);
                        opb_d   = '0;
                        neg_d   = 1'b0;
                        ovf_d   = 1'b0;
                        state_d = ENTER_A;
                    end else begin
                        case (digit)
                            4'hA, 4'hB: if (flags_clr) begin
                                opa_d    = res_q;
                                opb_d    = '0;
                                op_sub_d = digit[0];
                                state_d  = ENTER_B;
                            end
                            4'hC: clear = 1'b1;
                            4'hD: if (flags_clr) begin
                                opa_d   = res_q;
                                state_d = COMPARE;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: state_d = ENTER_A;
        endcase

        if (act_wr) begin
            if (state_q == ENTER_B) opb_d = act_new;
            else opa_d = act_new;
        end

        busy_d = (state_q == COMPARE) || (state_q == COMPUTE);
        case (state_q)
            ENTER_A: begin
                bcd_out_d  = opa_q;
                negative_d = 1'b0;
                overflow_d = 1'b0;
            end
            ENTER_B: begin
                bcd_out_d  = opb_q;
                negative_d = 1'b0;
                overflow_d = 1'b0;
            end
            RESULT: begin
                bcd_out_d  = res_q;
                negative_d = neg_q;
                overflow_d = ovf_q;
            end
            default: ;
        endcase

        if (clear) begin
            state_d    = ENTER_A;
            opa_d      = '0;
            opb_d      = '0;
            op_sub_d   = 1'b0;
            neg_d      = 1'b0;
            ovf_d      = 1'b0;
            bcd_out_d  = '0;
            negative_d = 1'b0;
            overflow_d = 1'b0;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ENTER_A;
            opa_q      <= '0;
            opb_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            res_q      <= '0;
            op_sub_q   <= 1'b0;
            carry_q    <= 1'b0;
            neg_q      <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= 4'd0;
            bcd_out_q  <= '0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            x_q        <= x_d;
            y_q        <= y_d;
            res_q      <= res_d;
            op_sub_q   <= op_sub_d;
            carry_q    <= carry_d;
            neg_q      <= neg_d;
            ovf_q      <= ovf_d;
            cnt_q      <= cnt_d;
            bcd_out_q  <= bcd_out_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign bcd_out  = bcd_out_q;
    assign negative = negative_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: doc/bcd_calc_core.md
Name: bcd_calc_core

Overview:
- Parametrised successor to the three-digit BCD display register: an NDIGITS-wide BCD entry register plus a two-operand add/subtract engine.
- Consumes the debounced, edge-triggered keycode/keystrobe pair from the keypad path.
- Drives the char_7seg digit decoders with the active operand or the result.
- Adds operator keys, backspace, digit-entry saturation, digit-serial BCD arithmetic, sign and overflow flags.

Parameters:
- NDIGITS, 3, number of BCD digits per operand and result (legal range 1..8).

Ports:
- clock  input  1  system clock (clockmain).
- reset  input  1  synchronous, active-high reset.
- digit  input  4  keycode: 0-9 digit, A add, B subtract, C clear, D equals, E backspace, F ignored.
- keystrobe  input  1  single-cycle strobe; digit is valid when high.
- bcd_out  output  4*NDIGITS  displayed value; digit 0 (LSD) in [3:0].
- negative  output  1  result is negative; bcd_out holds the magnitude.
- overflow  output  1  addition carried out of the MSD.
- busy  output  1  high during COMPARE/COMPUTE.

Behaviour:
- Reset at the clock edge with reset=1:
  - state=ENTER_A; opA=opB=0; op=add.
  - bcd_out=0; negative=0; overflow=0; busy=0.
  - Reset wins over a coincident keystrobe.
  - Reset during COMPUTE aborts the calculation.
- States: ENTER_A, ENTER_B, COMPARE, COMPUTE, RESULT.
- Keystrobe with F: ignored in every state.
- Clear (C):
  - Acts like reset in every state except COMPARE/COMPUTE, where it is ignored.
- Keystrobes while busy=1 are dropped, not queued.
- Digit key (ENTER_A/ENTER_B), applied to the active operand:
  - Operand shifts left one digit; new digit enters the LSD.
  - If the MSD is already nonzero, the operand is full and the key is ignored. No MSD discard.
  - Leading zeros do not count toward full.
- Backspace (E): active operand shifts right one digit; MSD becomes 0.
- Operator keys:
  - A/B in ENTER_A: latch op, set opB=0, go to ENTER_B.
  - A/B in ENTER_B: replace op; opB unchanged.
  - D in ENTER_A: no-op.
  - D in ENTER_B: go to COMPARE; busy=1 on the next cycle.
- COMPARE: 1 cycle.
  - For subtract, swap so larger magnitude minus smaller; negative=1 iff opA<opB.
  - For add, no swap.
- COMPUTE: NDIGITS cycles, one digit per cycle, LSD first.
  - Carry/borrow register is cleared at COMPUTE entry.
  - Add: sum>9 gives sum+6 and carry.
  - Subtract: diff<0 gives diff+10 and borrow.
- Latency:
  - Result valid and busy=0 on cycle NDIGITS+2 after the equals keystrobe cycle (equals edge = cycle 0).
  - For NDIGITS=3, that is cycle 5.
- RESULT:
  - bcd_out=result.
  - overflow=1 iff the final add carry is 1; bcd_out then shows the truncated sum.
- Key handling in RESULT:
  - Digit key: clear flags; opA = that digit; opB=0; go to ENTER_A.
  - A/B with negative=0 and overflow=0: opA=result; latch op; go to ENTER_B (chaining).
  - A/B with either flag set: ignored.
  - D: repeat the last operation with the same opB on opA=result; same flag conditions as A/B.
  - E: ignored.
- Display:
  - ENTER_A shows opA; ENTER_B shows opB.
  - COMPARE/COMPUTE hold the previous bcd_out.
  - RESULT shows the result.
- Outputs are registered; there is no combinational path from digit/keystrobe to any output.
- Input digits 0-9 only; operands never hold non-BCD nibbles.

Test Plan:
- Reset, then 1,2,3,4 strobes: bcd_out=0x123 (fourth digit ignored). Then E: 0x012.
- 4,5, A, 7,8, D: busy high exactly cycles 1-4 after D; cycle 5 gives bcd_out=0x123, negative=0, overflow=0.
- 1,2, B, 3,0, D: bcd_out=0x018, negative=1. Then A: ignored, state stays RESULT.
- 9,9,9, A, 1, D: overflow=1, bcd_out=0x000. Then digit 5: bcd_out=0x005, overflow=0.
- Chaining 2, A, 3, D, D: results 0x005 then 0x008. Inject a C strobe mid-COMPUTE: ignored, and the result is still correct.
- Assert reset in the same cycle as a keystrobe with digit 7, and on COMPUTE cycle 2: all outputs 0, state ENTER_A. Repeat with NDIGITS=1 and NDIGITS=6 for width coverage.
